// File: rtl/accumulator_pkg.sv
// Shared types and arithmetic helper for the accumulator bank.
package accumulator_pkg;

  // Widest accumulator the arithmetic helper supports
  localparam int unsigned MAX_W = 64;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LOAD = 4'd1,
    OP_INC  = 4'd2,
    OP_DEC  = 4'd3,
    OP_ADD  = 4'd4,
    OP_SUB  = 4'd5,
    OP_CLR  = 4'd6,
    OP_MAC  = 4'd7
  } acc_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    WRITE = 2'd2
  } acc_state_e;

  // Unsigned add/sub of w-bit operands; returns {overflow, result}.
  // With sat set, an overflow clamps to all-ones (add) or zero (sub).
  function automatic logic [MAX_W:0] sat_addsub(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic             sub,
    input logic             sat,
    input int unsigned      w
  );
    logic [MAX_W:0]   sum;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] res;
    logic             ovf;
    mask = {MAX_W{1'b1}} >> (MAX_W - w);
    if (sub) begin
      sum = {1'b0, a} - {1'b0, b};
      ovf = (a < b);
    end else begin
      sum = {1'b0, a} + {1'b0, b};
      ovf = ((sum >> w) != '0);
    end
    res = sum[MAX_W-1:0] & mask;
    if (sat && ovf) begin
      res = sub ? '0 : mask;
    end
    return {ovf, res};
  endfunction

endpackage

// File: rtl/acc_seq_multiplier.sv
// Shift-add multiplier: one multiplier bit per cycle, LSB first.
// Bit 0 is consumed on the start edge; done pulses when the product is final,
// WIDTH cycles after start. The product holds until the next start.
module acc_seq_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic [2*WIDTH-1:0]   product,
  output logic                 done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [PW-1:0]    mcand_q;
  logic [PW-1:0]    prod_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic             done_q;

  // Operand latch and shift-add iteration
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
      done_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= PW'(multiplicand) << 1;
      prod_q   <= multiplier[0] ? PW'(multiplicand) : '0;
      mplier_q <= multiplier >> 1;
      cnt_q    <= CW'(WIDTH - 1);
      run_q    <= 1'b1;
      done_q   <= 1'b0;
    end else if (run_q) begin
      if (mplier_q[0]) begin
        prod_q <= prod_q + mcand_q;
      end
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_q  <= 1'b0;
        done_q <= 1'b1;
      end
    end else begin
      done_q <= 1'b0;
    end
  end

  assign product = prod_q;
  assign done    = done_q;

endmodule

// File: rtl/accumulator_bank.sv
// Bank of NUM_ACC WIDTH-bit accumulators behind a valid/ready command port.
// Define ACCUMULATOR_BANK_SATURATE_EN to clamp INC/ADD/MAC at all-ones and
// DEC/SUB at zero instead of wrapping.
module accumulator_bank
  import accumulator_pkg::*;
#(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned NUM_ACC = 4,
  localparam int unsigned SEL_W   = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cmd_operand,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             busy,
  output logic             done
);

  localparam int unsigned SEL_W1 = SEL_W + 1;
  localparam logic [SEL_W1-1:0] NUM_ACC_S = SEL_W1'(NUM_ACC);
  localparam int unsigned PW = 2 * WIDTH;

`ifdef ACCUMULATOR_BANK_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  acc_state_e       state_q, state_d;
  logic [WIDTH-1:0] acc_q [NUM_ACC];
  logic [WIDTH-1:0] acc_d [NUM_ACC];
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic [SEL_W-1:0] mac_sel_q, mac_sel_d;

  logic             mul_start_c;
  logic             mul_done;
  logic [PW-1:0]    mul_product;

  acc_op_e          op;
  logic [SEL_W-1:0] tgt_sel;
  logic             tgt_ok;
  logic [WIDTH-1:0] tgt_val;
  logic [WIDTH-1:0] ar_b;
  logic             ar_sub;
  logic [MAX_W:0]   ar;
  logic [WIDTH-1:0] ar_val;
  logic             ar_ovf;
  logic             prod_hi;

  acc_seq_multiplier #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk          (clk),
    .reset        (reset),
    .start        (mul_start_c),
    .multiplicand (cmd_data),
    .multiplier   (cmd_operand),
    .product      (mul_product),
    .done         (mul_done)
  );

  // Target accumulator: the command's select when idle, the latched MAC select otherwise
  assign op      = acc_op_e'(cmd_op);
  assign tgt_sel = (state_q == IDLE) ? cmd_sel : mac_sel_q;
  assign tgt_ok  = {1'b0, tgt_sel} < NUM_ACC_S;
  assign tgt_val = tgt_ok ? acc_q[tgt_sel] : '0;
  assign prod_hi = |mul_product[PW-1:WIDTH];

  // Second operand and direction for the shared adder
  always_comb begin
    ar_b   = '0;
    ar_sub = 1'b0;
    if (state_q == WRITE) begin
      ar_b = mul_product[WIDTH-1:0];
    end else begin
      case (op)
        OP_INC:  ar_b = WIDTH'(1);
        OP_DEC: begin
          ar_b   = WIDTH'(1);
          ar_sub = 1'b1;
        end
        OP_ADD:  ar_b = cmd_data;
        OP_SUB: begin
          ar_b   = cmd_data;
          ar_sub = 1'b1;
        end
        default: ar_b = '0;
      endcase
    end
  end

  assign ar     = sat_addsub(MAX_W'(tgt_val), MAX_W'(ar_b), ar_sub, SAT, WIDTH);
  assign ar_val = WIDTH'(ar[MAX_W-1:0]);
  assign ar_ovf = ar[MAX_W];

  // Next-state, opcode decode and accumulator/flag update
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    done_d      = 1'b0;
    mac_sel_d   = mac_sel_q;
    mul_start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          done_d = 1'b1;
          if (tgt_ok) begin
            case (op)
              OP_LOAD: begin
                acc_d[tgt_sel] = cmd_data;
                zero_d         = (cmd_data == '0);
                carry_d        = 1'b0;
              end
              OP_INC, OP_DEC, OP_ADD, OP_SUB: begin
                acc_d[tgt_sel] = ar_val;
                zero_d         = (ar_val == '0);
                carry_d        = ar_ovf;
              end
              OP_CLR: begin
                acc_d[tgt_sel] = '0;
                zero_d         = 1'b1;
                carry_d        = 1'b0;
              end
              OP_MAC: begin
                mul_start_c = 1'b1;
                mac_sel_d   = tgt_sel;
                done_d      = 1'b0;
                state_d     = MUL;
              end
              default: done_d = 1'b1;
            endcase
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (tgt_ok) begin
          if (SAT && prod_hi) begin
            acc_d[tgt_sel] = '1;
            zero_d         = 1'b0;
            carry_d        = 1'b1;
          end else begin
            acc_d[tgt_sel] = ar_val;
            zero_d         = (ar_val == '0);
            carry_d        = prod_hi | ar_ovf;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accumulator and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      zero_q    <= 1'b0;
      carry_q   <= 1'b0;
      done_q    <= 1'b0;
      mac_sel_q <= '0;
      for (int i = 0; i < NUM_ACC; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      zero_q    <= zero_d;
      carry_q   <= carry_d;
      done_q    <= done_d;
      mac_sel_q <= mac_sel_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign done       = done_q;
  assign rd_data    = ({1'b0, rd_sel} < NUM_ACC_S) ? acc_q[rd_sel] : '0;

endmodule

// File: tb/tb_accumulator_bank.sv
// Directed bench for accumulator_bank (WIDTH=8, NUM_ACC=4); expectations follow
// ACCUMULATOR_BANK_SATURATE_EN when it is defined.
module tb_accumulator_bank;

`ifdef ACCUMULATOR_BANK_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_sel;
  logic [7:0] cmd_data;
  logic [7:0] cmd_operand;
  logic [1:0] rd_sel;
  logic [7:0] rd_data;
  logic       zero_flag;
  logic       carry_flag;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] op;
    logic [1:0] sel;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic       exp_zero;
    logic       exp_carry;
  } vec_t;

  vec_t vecs [15];

  accumulator_bank #(
    .WIDTH   (8),
    .NUM_ACC (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_sel     (cmd_sel),
    .cmd_data    (cmd_data),
    .cmd_operand (cmd_operand),
    .rd_sel      (rd_sel),
    .rd_data     (rd_data),
    .zero_flag   (zero_flag),
    .carry_flag  (carry_flag),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One command accepted at the next rising edge; returns 1 time unit after it
  task automatic issue(input logic [3:0] op, input logic [1:0] sel,
                       input logic [7:0] d, input logic [7:0] o);
    @(negedge clk);
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_sel     = sel;
    cmd_data    = d;
    cmd_operand = o;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // MAC with noise on cmd_* while busy; reports cycles to done and cycles not ready
  task automatic run_mac(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                         output int cyc, output int low, output logic mid_busy);
    mid_busy = 1'b0;
    issue(4'd7, sel, a, b);
    cyc = 0;
    low = 0;
    while (!done && cyc < 20) begin
      if (!cmd_ready) low++;
      if (cyc == 3) mid_busy = busy;
      if (cyc == 2) begin
        cmd_valid   = 1'b1;
        cmd_op      = 4'd1;
        cmd_data    = 8'h55;
        cmd_operand = 8'hAA;
      end
      if (cyc == 5) cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic check_all_clear(input string tag);
    for (int r = 0; r < 4; r++) begin
      rd_sel = 2'(r);
      #1;
      check($sformatf("%s acc%0d", tag, r), rd_data, 0);
    end
    check({tag, " zero"}, zero_flag, 0);
    check({tag, " carry"}, carry_flag, 0);
    check({tag, " ready"}, cmd_ready, 1);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
  endtask

  initial begin
    int   cyc;
    int   low;
    int   ndone;
    logic mid_busy;

    vecs[0]  = '{4'd1, 2'd2, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[1]  = '{4'd2, 2'd2, 8'h00, SAT ? 8'hFF : 8'h00, SAT ? 1'b0 : 1'b1, 1'b1};
    vecs[2]  = '{4'd1, 2'd3, 8'h05, 8'h05, 1'b0, 1'b0};
    vecs[3]  = '{4'd5, 2'd3, 8'h07, SAT ? 8'h00 : 8'hFE, SAT ? 1'b1 : 1'b0, 1'b1};
    vecs[4]  = '{4'hB, 2'd3, 8'h42, SAT ? 8'h00 : 8'hFE, SAT ? 1'b1 : 1'b0, 1'b1};
    vecs[5]  = '{4'd1, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{4'd3, 2'd0, 8'h00, SAT ? 8'h00 : 8'hFF, SAT ? 1'b1 : 1'b0, 1'b1};
    vecs[7]  = '{4'd6, 2'd0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{4'd4, 2'd0, 8'h80, 8'h80, 1'b0, 1'b0};
    vecs[9]  = '{4'd4, 2'd0, 8'h90, SAT ? 8'hFF : 8'h10, 1'b0, 1'b1};
    vecs[10] = '{4'd1, 2'd1, 8'h10, 8'h10, 1'b0, 1'b0};
    vecs[11] = '{4'd0, 2'd1, 8'h77, 8'h10, 1'b0, 1'b0};
    vecs[12] = '{4'd2, 2'd1, 8'h00, 8'h11, 1'b0, 1'b0};
    vecs[13] = '{4'd3, 2'd1, 8'h00, 8'h10, 1'b0, 1'b0};
    vecs[14] = '{4'hF, 2'd1, 8'h99, 8'h10, 1'b0, 1'b0};

    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = 4'd0;
    cmd_sel     = 2'd0;
    cmd_data    = 8'h00;
    cmd_operand = 8'h00;
    rd_sel      = 2'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_clear("reset");

    // Single-cycle opcodes from the table
    for (int i = 0; i < 15; i++) begin
      rd_sel = vecs[i].sel;
      issue(vecs[i].op, vecs[i].sel, vecs[i].data, 8'h00);
      check($sformatf("vec%0d done", i), done, 1);
      check($sformatf("vec%0d rd", i), rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d zero", i), zero_flag, vecs[i].exp_zero);
      check($sformatf("vec%0d carry", i), carry_flag, vecs[i].exp_carry);
    end

    // MAC acc1 = 0x10 + 0x0C*0x0A
    rd_sel = 2'd1;
    run_mac(2'd1, 8'h0C, 8'h0A, cyc, low, mid_busy);
    check("mac1 latency", cyc, 9);
    check("mac1 not-ready cycles", low, 9);
    check("mac1 busy mid", mid_busy, 1);
    check("mac1 busy after", busy, 0);
    check("mac1 rd", rd_data, 8'h88);
    check("mac1 zero", zero_flag, 0);
    check("mac1 carry", carry_flag, 0);
    @(posedge clk);
    #1;
    check("mac1 done one cycle", done, 0);

    // MAC acc0 = 0 + 0x20*0x10 (product overflows WIDTH)
    rd_sel = 2'd0;
    issue(4'd6, 2'd0, 8'h00, 8'h00);
    check("clr0 rd", rd_data, 8'h00);
    run_mac(2'd0, 8'h20, 8'h10, cyc, low, mid_busy);
    check("mac0 latency", cyc, 9);
    check("mac0 rd", rd_data, SAT ? 8'hFF : 8'h00);
    check("mac0 zero", zero_flag, SAT ? 1'b0 : 1'b1);
    check("mac0 carry", carry_flag, 1);

    // Back-to-back ADD then LOAD on acc0
    @(negedge clk);
    rd_sel    = 2'd0;
    cmd_valid = 1'b1;
    cmd_op    = 4'd4;
    cmd_sel   = 2'd0;
    cmd_data  = 8'h03;
    check("b2b pre rd", rd_data, SAT ? 8'hFF : 8'h00);
    check("b2b pre ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    check("b2b add done", done, 1);
    check("b2b add rd", rd_data, SAT ? 8'hFF : 8'h03);
    check("b2b add carry", carry_flag, SAT ? 1'b1 : 1'b0);
    check("b2b ready", cmd_ready, 1);
    cmd_op   = 4'd1;
    cmd_data = 8'h44;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("b2b load done", done, 1);
    check("b2b load rd", rd_data, 8'h44);
    check("b2b load carry", carry_flag, 0);

    // Reset in the middle of a MAC
    issue(4'd1, 2'd3, 8'h33, 8'h00);
    issue(4'd7, 2'd3, 8'h05, 8'h05);
    repeat (3) @(posedge clk);
    #2;
    check("midmac busy", busy, 1);
    reset = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset ready", cmd_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    check("no done after abort", ndone, 0);
    check_all_clear("abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
